// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, constants and fetch state encoding
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0]   PC_INC    = 32'd4;
    localparam logic [INST_W-1:0] HALT_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular fetch buffer holding {pc, inst} pairs
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // Flush wins over everything; full/empty guard the pointers.
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rptr];

    // Storage array needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch initiator with PC, FSM and fetch buffer
module inst_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [XLEN-1:0]   imem_addr,
    output logic              imem_req,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              imem_valid,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              halted,
    output logic              misalign_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t              state;
    fetch_state_t              state_nxt;
    logic [XLEN-1:0]           pc;
    logic [XLEN-1:0]           pc_nxt;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;
    logic [XLEN+INST_W-1:0]    fifo_head;

    fetch_fifo #(
        .WIDTH (XLEN + INST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({pc, imem_inst}),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);
    assign out_valid = (fifo_count != '0);
    assign out_pc    = fifo_empty ? '0 : fifo_head[XLEN+INST_W-1:INST_W];
    assign out_inst  = fifo_empty ? '0 : fifo_head[INST_W-1:0];
    // A pop in the redirect cycle is thrown away with the flush.
    assign pop       = out_valid && out_ready && !redirect_valid;

    // Request/accept decode and next PC/state; redirect overrides all.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        imem_req  = (state == ST_RUN) && !fifo_full && !redirect_valid;
        accept    = imem_req && imem_valid;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (accept && (imem_inst == HALT_INST)) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_BOOT;
        endcase
        if (accept && (imem_inst != HALT_INST)) begin
            push   = 1'b1;
            pc_nxt = pc + PC_INC;
        end
        if (redirect_valid) begin
            pc_nxt    = {redirect_pc[XLEN-1:2], 2'b00};
            state_nxt = ST_RUN;
        end
    end

    // PC, state and misalignment pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_BOOT;
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_inst;
    logic        imem_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        halted;
    logic        misalign_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic [31:0] mem [64];
    ent_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          sb_on    = 1'b0;
    bit          exp_mis  = 1'b0;
    bit          mis_pend = 1'b0;

    always #5 clk = ~clk;

    // Combinational program memory; everything past 0xFF reads as zero.
    always_comb imem_inst = (imem_addr < 32'd256) ? mem[imem_addr[7:2]] : 32'h0;

    inst_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_inst      (imem_inst),
        .imem_valid     (imem_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .halted         (halted),
        .misalign_err   (misalign_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: from an aligned start, the decode stage sees every
    // nonzero word in address order until the first zero word.
    task automatic load_stream(input logic [31:0] start);
        logic [31:0] a;
        ent_t        e;
        exp_q.delete();
        a = start & ~32'h3;
        while (a < 32'd256 && mem[a[7:2]] != 32'h0) begin
            e.pc   = a;
            e.inst = mem[a[7:2]];
            exp_q.push_back(e);
            a = a + 32'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        exp_mis        = mis_pend;
        mis_pend       = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        mis_pend       = (target[1:0] != 2'b00);
        load_stream(target);
    endtask

    task automatic wait_halt(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (halted && !out_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk({name, "_halted"}, 32'(ok), 32'd1);
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare every accepted output against the reference stream.
    always @(negedge clk) begin
        ent_t e;
        if (sb_on && rst) begin
            chk("misalign_err", 32'(misalign_err), 32'(exp_mis));
            if (out_valid && out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual_pc=%h required=none", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_inst", out_inst, e.inst);
                end
            end
        end
    end

    initial begin
        rst            = 1'b0;
        imem_valid     = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h0050_0093;
        mem[1]  = 32'h0010_0113;
        for (int i = 4; i < 9; i++) mem[i] = 32'h0000_0100 + 32'(i);
        mem[8]  = 32'h00a0_0093;
        mem[16] = 32'h0030_0193;
        mem[17] = 32'h0000_0013;

        // Reset values
        @(negedge clk);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);

        // Boot cycle, then fetch 0, 4, 8 and halt on the zero word
        step();
        rst = 1'b1;
        load_stream(32'h0);
        sb_on = 1'b1;
        @(negedge clk);
        chk("boot_req", 32'(imem_req), 32'd0);
        step();
        @(negedge clk);
        chk("run_req", 32'(imem_req), 32'd1);
        chk("run_addr0", imem_addr, 32'h0);
        step();
        @(negedge clk);
        chk("run_addr4", imem_addr, 32'h4);
        step();
        @(negedge clk);
        chk("run_addr8", imem_addr, 32'h8);
        wait_halt("t1");

        // Misaligned redirect out of halt
        step();
        redirect(32'h46);
        @(negedge clk);
        chk("redir_req", 32'(imem_req), 32'd0);
        step();
        @(negedge clk);
        chk("mis_addr", imem_addr, 32'h44);
        chk("mis_pulse", 32'(misalign_err), 32'd1);
        chk("mis_unhalt", 32'(halted), 32'd0);
        step();
        @(negedge clk);
        chk("mis_pulse_end", 32'(misalign_err), 32'd0);
        wait_halt("t4");

        // Memory stall at 0x20 for three cycles
        step();
        redirect(32'h20);
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_addr", imem_addr, 32'h20);
            chk("stall_out_valid", 32'(out_valid), 32'd0);
        end
        step();
        imem_valid = 1'b1;
        wait_halt("t6");

        // Fill the buffer from halt, then redirect while full
        step();
        out_ready = 1'b0;
        redirect(32'h10);
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_addr", imem_addr, 32'h18);
        chk("full_head_pc", out_pc, 32'h10);
        step();
        redirect(32'h40);
        step();
        @(negedge clk);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_addr", imem_addr, 32'h40);
        step();
        out_ready = 1'b1;
        wait_halt("t3");

        // Asynchronous reset mid-stream
        step();
        redirect(32'h10);
        step();
        step();
        @(posedge clk);
        #3;
        rst      = 1'b0;
        sb_on    = 1'b0;
        exp_mis  = 1'b0;
        mis_pend = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);

        // Random program, handshakes, stalls and redirects
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        load_stream(32'h0);
        sb_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            out_ready  = ($urandom_range(0, 1) == 1);
            imem_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) redirect($urandom_range(0, 255));
        end
        step();
        out_ready  = 1'b1;
        imem_valid = 1'b1;
        wait_halt("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch initiator that drives the instruction memory's address port and collects returned words. It sits between the PC-redirect logic (branch/jump resolution) and the decode stage. It holds the PC, issues word-aligned fetches, buffers {pc, inst} pairs in a small FIFO, and offers them to decode over a valid/ready handshake. It stops fetching on an all-zero instruction word, which the memory returns while held in reset or past the end of the program.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FIFO_DEPTH, 2, fetch-buffer entries; power of 2, minimum 2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset (0 = reset).
imem_addr  output  32  fetch address; always equals the PC register, with bits [1:0] always 0.
imem_req  output  1  fetch request for imem_addr this cycle.
imem_inst  input  32  returned instruction word.
imem_valid  input  1  imem_inst is valid for the current request; tie to 1 for a combinational memory.
redirect_valid  input  1  one-cycle PC redirect strobe.
redirect_pc  input  32  redirect target.
out_valid  output  1  out_pc/out_inst hold a fetched instruction.
out_ready  input  1  decode accepts the entry this cycle.
out_pc  output  32  address of out_inst.
out_inst  output  32  fetched instruction.
halted  output  1  high in ST_HALT.
misalign_err  output  1  one-cycle pulse when a redirect target has bits [1:0] != 0.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, FIFO emptied, state=ST_BOOT. All outputs are 0 except imem_addr=RESET_PC.
- States:
  - ST_BOOT: one cycle, no request, then go to ST_RUN.
  - ST_RUN: normal fetching.
  - ST_HALT: no requests issued; FIFO continues to drain.
- imem_req = (state==ST_RUN) && (count < FIFO_DEPTH) && !redirect_valid.
- Accept: imem_req && imem_valid in the same cycle.
  - If imem_inst != 0: push {pc, imem_inst} and set pc <= pc+4. The add wraps modulo 2^32.
  - If imem_inst == 0: no push, pc unchanged, go to ST_HALT.
- If imem_valid=0 while requesting: hold pc and imem_req; the request repeats next cycle.
- Pop: out_valid && out_ready. out_valid = (count != 0). out_pc/out_inst show the FIFO head; they are 0 when empty. There is no bypass, so minimum fetch-to-out_valid latency is 1 cycle.
- Simultaneous push and pop: both take effect and count is unchanged. When full, push is blocked regardless of pop in the same cycle (imem_req already low).
- Redirect (any state):
  - Next cycle: pc <= {redirect_pc[31:2], 2'b00}, FIFO flushed (count=0, out_valid=0), state <= ST_RUN.
  - Any pop or memory response in the redirect cycle is discarded. imem_req is 0 in the redirect cycle.
  - misalign_err pulses in the cycle after a redirect whose redirect_pc[1:0] != 0.
- Redirect during ST_BOOT: takes priority; go to ST_RUN with the new pc.
- Reset mid-operation: immediate return to reset values; an in-flight request is abandoned.
- FIFO: circular buffer with log2(FIFO_DEPTH)-bit read/write pointers and a (log2+1)-bit count; pointers wrap naturally.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN=32, INST_W=32.
  - PC increment constant 4.
  - HALT_INST=32'h0000_0000.
  - State encodings ST_BOOT=2'd0, ST_RUN=2'd1, ST_HALT=2'd2.
- Sub-module fetch_fifo:
  - Parameterised width 64 ({pc, inst}) and depth.
  - Ports: push, pop, flush, full, empty, count, head data.
  - Same clk/rst convention.
- inst_fetch holds the PC, the state machine and the request logic.

Test Plan:
1. Reset release, combinational memory (imem_valid=1) holding 0x00500093, 0x00100113, 0x00000000 at words 0..2, out_ready=1 -> ST_BOOT for 1 cycle, imem_addr 0 then 4 then 8. out_pc/out_inst pairs (0, 0x00500093) and (4, 0x00100113) appear in order. halted=1 after the fetch at 8; out_valid=0 afterwards.
2. out_ready=0 with a full program -> exactly FIFO_DEPTH (2) entries pushed, imem_req=0, imem_addr=8. Raise out_ready -> entries drain in order and fetching resumes at 8 with no duplicate or lost pc.
3. FIFO full, then redirect_valid=1 with redirect_pc=0x40 -> next cycle out_valid=0 and imem_addr=0x40. The first new output is out_pc=0x40; no stale entries appear.
4. redirect_pc=0x46 -> pc=0x44 and misalign_err is high for exactly 1 cycle.
5. While in ST_HALT, redirect to 0x10 -> halted=0, fetching restarts at 0x10.
6. imem_valid stalled low for 3 cycles at pc=0x20 -> imem_req and imem_addr=0x20 held for 3 cycles, no push. Also: rst asserted mid-stream -> outputs return to reset values in the same cycle, asynchronously.
